// File: rtl/warp_scheduler.sv
// Single-issue warp scheduler: sequences one warp at a time through the instruction lifecycle
// and rotates round-robin among live warps. Optional perf counters: define WARP_SCHED_PERF_EN.

package warp_scheduler_pkg;
    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;
endpackage

// Fetch handshake: fetch_req is high for every FETCH cycle; the fetcher answers with
// fetch_ready=1 in a cycle where fetch_req=1, and the request retires on that clock edge.
module warp_scheduler
    import warp_scheduler_pkg::*;
#(
    parameter int NUM_WARPS     = 4,
    parameter int WARP_ID_WIDTH = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [NUM_WARPS-1:0]     warp_active_mask,
    output logic                     fetch_req,
    input  logic                     fetch_ready,
    input  logic                     decoded_ret,
    input  logic                     decoded_mem_access,
    input  logic                     lsu_done,
    output warp_state_t              warp_state,
    output logic [WARP_ID_WIDTH-1:0] current_warp,
    output logic [NUM_WARPS-1:0]     warp_enable,
    output logic                     done,
    output logic [31:0]              perf_instr_count,
    output logic [31:0]              perf_stall_cycles
);

    logic [NUM_WARPS-1:0]     live;
    logic [NUM_WARPS-1:0]     live_after;
    logic [WARP_ID_WIDTH-1:0] next_warp;
    logic                     next_found;
    logic [WARP_ID_WIDTH-1:0] first_warp;
    logic                     launch;

    function automatic logic [NUM_WARPS-1:0] onehot(input logic [WARP_ID_WIDTH-1:0] w);
        logic [NUM_WARPS-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    assign launch = start && (warp_state == WARP_IDLE || warp_state == WARP_DONE);

    // Next live warp after the current one; the current warp is considered last.
    always_comb begin
        int                       idx;
        logic [WARP_ID_WIDTH-1:0] cand;
        idx        = 0;
        cand       = '0;
        live_after = live;
        next_warp  = current_warp;
        next_found = 1'b0;
        if (decoded_ret) begin
            live_after[current_warp] = 1'b0;
        end
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx  = (int'(current_warp) + i) % NUM_WARPS;
            cand = WARP_ID_WIDTH'(idx);
            if (!next_found && live_after[cand]) begin
                next_found = 1'b1;
                next_warp  = cand;
            end
        end
    end

    always_comb begin
        first_warp = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (warp_active_mask[WARP_ID_WIDTH'(i)]) begin
                first_warp = WARP_ID_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            warp_state   <= WARP_IDLE;
            current_warp <= '0;
            warp_enable  <= '0;
            fetch_req    <= 1'b0;
            done         <= 1'b0;
            live         <= '0;
        end else begin
            case (warp_state)
                WARP_IDLE, WARP_DONE: begin
                    if (start) begin
                        live <= warp_active_mask;
                        if (warp_active_mask == '0) begin
                            warp_state <= WARP_DONE;
                            done       <= 1'b1;
                        end else begin
                            warp_state   <= WARP_FETCH;
                            done         <= 1'b0;
                            current_warp <= first_warp;
                            warp_enable  <= onehot(first_warp);
                            fetch_req    <= 1'b1;
                        end
                    end
                end
                WARP_FETCH: begin
                    if (fetch_ready) begin
                        warp_state <= WARP_DECODE;
                        fetch_req  <= 1'b0;
                    end
                end
                WARP_DECODE:  warp_state <= WARP_REQUEST;
                WARP_REQUEST: warp_state <= WARP_WAIT;
                WARP_WAIT: begin
                    if (!decoded_mem_access || lsu_done) begin
                        warp_state <= WARP_EXECUTE;
                    end
                end
                WARP_EXECUTE: warp_state <= WARP_UPDATE;
                WARP_UPDATE: begin
                    live <= live_after;
                    if (next_found) begin
                        warp_state   <= WARP_FETCH;
                        current_warp <= next_warp;
                        warp_enable  <= onehot(next_warp);
                        fetch_req    <= 1'b1;
                    end else begin
                        warp_state  <= WARP_DONE;
                        warp_enable <= '0;
                        done        <= 1'b1;
                    end
                end
                default: begin
                    warp_state  <= WARP_IDLE;
                    warp_enable <= '0;
                    fetch_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef WARP_SCHED_PERF_EN
    logic [31:0] instr_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset || launch) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (warp_state == WARP_UPDATE) begin
                instr_cnt <= instr_cnt + 32'd1;
            end
            if ((warp_state == WARP_FETCH && !fetch_ready) ||
                (warp_state == WARP_WAIT && decoded_mem_access && !lsu_done)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_instr_count  = instr_cnt;
    assign perf_stall_cycles = stall_cnt;
`else
    assign perf_instr_count  = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: the driver pushes per-cycle expected outputs into a
// queue and a negedge monitor pops and compares them against the DUT.

module tb_warp_scheduler;
    import warp_scheduler_pkg::*;

    localparam int NW = 4;
    localparam int W  = 12;  // {care_warp, state[2:0], warp[1:0], enable[3:0], done, fetch_req}
`ifdef WARP_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [NW-1:0]     warp_active_mask;
    logic              fetch_req;
    logic              fetch_ready;
    logic              decoded_ret;
    logic              decoded_mem_access;
    logic              lsu_done;
    warp_state_t       warp_state;
    logic [1:0]        current_warp;
    logic [NW-1:0]     warp_enable;
    logic              done;
    logic [31:0]       perf_instr_count;
    logic [31:0]       perf_stall_cycles;

    int          total = 0;
    int          bad   = 0;
    logic        mon_en = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_e, mon_a, mon_m;

    warp_scheduler #(.NUM_WARPS(NW)) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .warp_active_mask   (warp_active_mask),
        .fetch_req          (fetch_req),
        .fetch_ready        (fetch_ready),
        .decoded_ret        (decoded_ret),
        .decoded_mem_access (decoded_mem_access),
        .lsu_done           (lsu_done),
        .warp_state         (warp_state),
        .current_warp       (current_warp),
        .warp_enable        (warp_enable),
        .done               (done),
        .perf_instr_count   (perf_instr_count),
        .perf_stall_cycles  (perf_stall_cycles)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        total++;
        bad++;
        $display("FAIL watchdog expired before end of test");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // expected-value encoding; w < 0 means current_warp is not checked
    function automatic logic [W-1:0] pack(input warp_state_t st, input int w, input bit d);
        logic [3:0] en;
        logic [1:0] wf;
        logic       act;
        act = (st == WARP_FETCH || st == WARP_DECODE || st == WARP_REQUEST ||
               st == WARP_WAIT || st == WARP_EXECUTE || st == WARP_UPDATE);
        wf  = (w >= 0) ? 2'(w) : 2'd0;
        en  = act ? 4'(1 << wf) : 4'b0000;
        return {(w >= 0), st, wf, en, d, (st == WARP_FETCH)};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL cycle_underflow got=state %0d want=<no expectation>", warp_state);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = {1'b1, warp_state, current_warp, warp_enable, done, fetch_req};
                mon_m = mon_e[11] ? 12'h7ff : 12'h73f;
                if (((mon_a ^ mon_e) & mon_m) != '0) begin
                    bad++;
                    $display("FAIL cycle_%0d got=%h want=%h (state,warp,en,done,freq)",
                             total, mon_a & mon_m, mon_e & mon_m);
                end
            end
        end
    end

    // driver tasks
    task automatic drive_cycle(input warp_state_t st, input int w, input bit d);
        exp_q.push_back(pack(st, w, d));
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [NW-1:0] m, input warp_state_t st, input int w, input bit d);
        start            = 1'b1;
        warp_active_mask = m;
        drive_cycle(st, w, d);
        start            = 1'b0;
    endtask

    task automatic run_instr(input int w, input int fstall, input bit mem, input int lstall,
                             input bit ret, input bit poke);
        decoded_ret        = ret;
        decoded_mem_access = mem;
        lsu_done           = 1'b1;
        fetch_ready        = 1'b0;
        for (int i = 0; i < fstall; i++) drive_cycle(WARP_FETCH, w, 1'b0);
        fetch_ready = 1'b1;
        drive_cycle(WARP_FETCH, w, 1'b0);
        fetch_ready = 1'b0;
        drive_cycle(WARP_DECODE, w, 1'b0);
        drive_cycle(WARP_REQUEST, w, 1'b0);
        if (mem) begin
            lsu_done = 1'b0;
            for (int i = 0; i < lstall; i++) drive_cycle(WARP_WAIT, w, 1'b0);
            lsu_done = 1'b1;
        end
        drive_cycle(WARP_WAIT, w, 1'b0);
        lsu_done = 1'b0;
        if (poke) begin
            start            = 1'b1;
            warp_active_mask = 4'b0100;
        end
        drive_cycle(WARP_EXECUTE, w, 1'b0);
        start = 1'b0;
        drive_cycle(WARP_UPDATE, w, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    initial begin
        reset              = 1'b1;
        start              = 1'b0;
        warp_active_mask   = '0;
        fetch_ready        = 1'b0;
        decoded_ret        = 1'b0;
        decoded_mem_access = 1'b0;
        lsu_done           = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        drive_cycle(WARP_IDLE, 0, 1'b0);
        reset = 1'b0;
        drive_cycle(WARP_IDLE, 0, 1'b0);
        chk("reset_instr", perf_instr_count, 32'd0);
        chk("reset_stall", perf_stall_cycles, 32'd0);

        // empty mask: DONE the cycle after start
        launch(4'b0000, WARP_IDLE, 0, 1'b0);
        drive_cycle(WARP_DONE, -1, 1'b1);
        drive_cycle(WARP_DONE, -1, 1'b1);

        // mask 0101, every warp returns on its first instruction
        launch(4'b0101, WARP_DONE, -1, 1'b1);
        run_instr(0, 0, 1'b0, 0, 1'b1, 1'b0);
        run_instr(2, 0, 1'b0, 0, 1'b1, 1'b0);
        drive_cycle(WARP_DONE, -1, 1'b1);

        // all four warps, two full rounds without RET, then a retiring round
        launch(4'b1111, WARP_DONE, -1, 1'b1);
        for (int r = 0; r < 3; r++)
            for (int w = 0; w < NW; w++)
                run_instr(w, 0, 1'b0, 0, (r == 2), 1'b0);
        drive_cycle(WARP_DONE, -1, 1'b1);
        chk("rr_instr", perf_instr_count, PERF ? 32'd12 : 32'd0);
        chk("rr_stall", perf_stall_cycles, 32'd0);

        // fetch stalled 3 cycles, LSU stalled 5 cycles
        launch(4'b0010, WARP_DONE, -1, 1'b1);
        run_instr(1, 3, 1'b1, 5, 1'b1, 1'b0);
        drive_cycle(WARP_DONE, -1, 1'b1);
        chk("stall_instr", perf_instr_count, PERF ? 32'd1 : 32'd0);
        chk("stall_cycles", perf_stall_cycles, PERF ? 32'd8 : 32'd0);

        // reset while warp 2 waits on the LSU, then a clean relaunch
        launch(4'b0100, WARP_DONE, -1, 1'b1);
        decoded_ret        = 1'b0;
        decoded_mem_access = 1'b1;
        fetch_ready        = 1'b1;
        drive_cycle(WARP_FETCH, 2, 1'b0);
        fetch_ready = 1'b0;
        drive_cycle(WARP_DECODE, 2, 1'b0);
        drive_cycle(WARP_REQUEST, 2, 1'b0);
        lsu_done = 1'b0;
        reset    = 1'b1;
        drive_cycle(WARP_WAIT, 2, 1'b0);
        reset = 1'b0;
        drive_cycle(WARP_IDLE, 0, 1'b0);
        chk("midreset_instr", perf_instr_count, 32'd0);
        chk("midreset_stall", perf_stall_cycles, 32'd0);
        launch(4'b0001, WARP_IDLE, 0, 1'b0);
        run_instr(0, 0, 1'b0, 0, 1'b1, 1'b0);
        drive_cycle(WARP_DONE, -1, 1'b1);

        // start during EXECUTE is ignored; later relaunch on warp 3 clears done
        launch(4'b0011, WARP_DONE, -1, 1'b1);
        run_instr(0, 0, 1'b0, 0, 1'b0, 1'b1);
        run_instr(1, 0, 1'b0, 0, 1'b1, 1'b0);
        run_instr(0, 0, 1'b0, 0, 1'b1, 1'b0);
        drive_cycle(WARP_DONE, -1, 1'b1);
        chk("poke_instr", perf_instr_count, PERF ? 32'd3 : 32'd0);
        launch(4'b1000, WARP_DONE, -1, 1'b1);
        run_instr(3, 0, 1'b0, 0, 1'b1, 1'b0);
        drive_cycle(WARP_DONE, -1, 1'b1);
        chk("relaunch_instr", perf_instr_count, PERF ? 32'd1 : 32'd0);

        mon_en = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
